alien_bomb_controller: RTL



---
 rtl/alien_bomb_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alien_bomb_controller.sv
// Alien return-fire bomb: every FIRE_PERIOD frames picks a pseudo-random column, launches a bomb
// from the lowest living alien in it, then drops it Y_SPEED/64 px per frame until collision or screen bottom.
module alien_bomb_controller #(
    parameter int ALIEN_ROW     = 4,
    parameter int ALIEN_COLUMN  = 8,
    parameter int PITCH_X       = 64,
    parameter int PITCH_Y       = 40,
    parameter int SHOT_X_OFFSET = 30,
    parameter int Y_SPEED       = 192,
    parameter int FIRE_PERIOD   = 60,
    parameter int BOTTOM_Y      = 479
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic                                playGame,
    input  logic                                bombCollision,
    input  logic [ALIEN_ROW*ALIEN_COLUMN-1:0]   aliensAlive,
    input  logic signed [10:0]                  gridTopLeftX,
    input  logic signed [10:0]                  gridTopLeftY,
    output logic signed [10:0]                  topLeftX,
    output logic signed [10:0]                  topLeftY,
    output logic                                alive
);

    localparam int ROW_W = (ALIEN_ROW > 1) ? $clog2(ALIEN_ROW) : 1;
    localparam int COL_W = (ALIEN_COLUMN > 1) ? $clog2(ALIEN_COLUMN) : 1;
    localparam int TRY_W = $clog2(ALIEN_COLUMN + 1);
    localparam int IDX_W = (ALIEN_ROW * ALIEN_COLUMN > 1) ? $clog2(ALIEN_ROW * ALIEN_COLUMN) : 1;
    localparam int FC_W  = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

    typedef enum logic [1:0] {COOLDOWN, PICK, SCAN, FLY} state_t;

    state_t             state_q;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [FC_W-1:0]    frame_cnt_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [TRY_W-1:0]   tried_q;
    logic signed [31:0] x_q, y_q;
    logic               alive_q;

    logic [COL_W-1:0]   pick_col;
    logic [IDX_W-1:0]   cell_idx;
    logic signed [31:0] spawn_x, spawn_y;
    logic signed [10:0] y_px;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting toward the MSB
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (!resetN) lfsr_q <= 8'hA5;
        else         lfsr_q <= lfsr_d;
    end

    always_comb begin
        pick_col = COL_W'(int'(lfsr_q[2:0]) % ALIEN_COLUMN);
        cell_idx = IDX_W'(int'(row_q) * ALIEN_COLUMN + int'(col_q));
        spawn_x  = (int'(gridTopLeftX) + int'(col_q) * PITCH_X + SHOT_X_OFFSET) * 64;
        spawn_y  = (int'(gridTopLeftY) + int'(row_q) * PITCH_Y + PITCH_Y) * 64;
        y_px     = 11'(y_q >>> 6);
    end

    always_ff @(posedge clk) begin
        if (!resetN || !playGame) begin
            state_q     <= COOLDOWN;
            frame_cnt_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tried_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            alive_q     <= 1'b0;
        end else begin
            case (state_q)
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (frame_cnt_q == FC_W'(FIRE_PERIOD - 1)) begin
                            frame_cnt_q <= '0;
                            state_q     <= PICK;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FC_W'(1);
                        end
                    end
                end
                PICK: begin
                    col_q   <= pick_col;
                    row_q   <= ROW_W'(ALIEN_ROW - 1);
                    tried_q <= '0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    // Bottom-up walk of one column, then on to the next, one cell per clock
                    if (tried_q == TRY_W'(ALIEN_COLUMN)) begin
                        state_q <= COOLDOWN;
                    end else if (aliensAlive[cell_idx]) begin
                        x_q     <= spawn_x;
                        y_q     <= spawn_y;
                        alive_q <= 1'b1;
                        state_q <= FLY;
                    end else if (row_q != '0) begin
                        row_q <= row_q - ROW_W'(1);
                    end else begin
                        col_q   <= (col_q == COL_W'(ALIEN_COLUMN - 1)) ? '0 : col_q + COL_W'(1);
                        row_q   <= ROW_W'(ALIEN_ROW - 1);
                        tried_q <= tried_q + TRY_W'(1);
                    end
                end
                FLY: begin
                    if (bombCollision || (y_px >= BOTTOM_Y)) begin
                        alive_q <= 1'b0;
                        state_q <= COOLDOWN;
                    end else if (startOfFrame) begin
                        y_q <= y_q + Y_SPEED;
                    end
                end
                default: state_q <= COOLDOWN;
            endcase
        end
    end

    assign topLeftX = 11'(x_q >>> 6);
    assign topLeftY = y_px;
    assign alive    = alive_q;

endmodule
